// File: rtl/cam_line_packer_pkg.sv
// Shared definitions for the camera line packer: FSM encoding, bank-select bit and sizing defaults.
package cam_line_packer_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    WAIT_LINE  = 2'd1,
    CAPTURE    = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  localparam int         BANK_BIT          = 9;
  localparam int         MAX_WORDS_DEFAULT = 320;
  localparam logic [8:0] LINE_COUNT_MAX    = 9'd511;

endpackage

// File: rtl/cam_pixel_packer.sv
// Packs camera bytes into RGB565 pixels and pixel pairs into 32-bit words (even pixel in [15:0]).
module cam_pixel_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_ready,
  output logic [31:0] word,
  output logic        pixel_held,
  output logic [31:0] half_word
);

  logic [1:0]  byte_cnt;
  logic [7:0]  byte_hi;
  logic [15:0] pix_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      byte_hi  <= 8'd0;
      pix_lo   <= 16'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      byte_hi  <= 8'd0;
      pix_lo   <= 16'd0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0, 2'd2: byte_hi <= byte_data;
        2'd1:       pix_lo  <= {byte_hi, byte_data};
        default:    byte_hi <= 8'd0;
      endcase
    end
  end

  // The fourth byte completes the word in the same cycle it arrives.
  assign word_ready = byte_en && (byte_cnt == 2'd3);
  assign word       = {byte_hi, byte_data, pix_lo};
  assign pixel_held = byte_cnt[1];
  assign half_word  = {16'h0000, pix_lo};

endmodule

// File: rtl/cam_line_packer.sv
// Camera line capture into a word RAM with line/frame bookkeeping.
// Optional LINE_PINGPONG_EN alternates lines between two RAM banks via mem_ad[9].
module cam_line_packer
  import cam_line_packer_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_valid,
  input  logic [7:0]  cam_data,
  output logic        mem_ce,
  output logic        mem_wre,
  output logic [9:0]  mem_ad,
  output logic [31:0] mem_din,
  output logic        line_done,
  output logic [9:0]  line_words,
  output logic [8:0]  line_count,
  output logic        frame_start,
  output logic        overflow
);

  state_t      state, state_next;
  logic        vsync_q;
  logic        vs_rise;
  logic        byte_en;
  logic        pk_clear;
  logic        flush_wr;
  logic        finish;
  logic        word_ready;
  logic        pixel_held;
  logic [31:0] word;
  logic [31:0] half_word;
  logic [9:0]  word_idx;
  logic        bank;

  cam_pixel_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .byte_en    (byte_en),
    .byte_data  (cam_data),
    .word_ready (word_ready),
    .word       (word),
    .pixel_held (pixel_held),
    .half_word  (half_word)
  );

  assign vs_rise = cam_valid && cam_vsync && !vsync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_FRAME;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    byte_en    = 1'b0;
    pk_clear   = 1'b0;
    flush_wr   = 1'b0;
    finish     = 1'b0;
    if (vs_rise) begin
      state_next = WAIT_FRAME;
      pk_clear   = 1'b1;
    end else begin
      case (state)
        WAIT_FRAME: if (cam_valid && !cam_vsync) state_next = WAIT_LINE;
        WAIT_LINE: begin
          if (cam_valid && cam_href) begin
            byte_en    = 1'b1;
            state_next = CAPTURE;
          end
        end
        CAPTURE: begin
          if (cam_valid) begin
            if (cam_href) byte_en    = 1'b1;
            else          state_next = FLUSH;
          end
        end
        FLUSH: begin
          // A held pixel is written first; the following FLUSH cycle then closes the line.
          pk_clear = 1'b1;
          if (pixel_held) begin
            flush_wr = 1'b1;
          end else begin
            finish     = 1'b1;
            state_next = WAIT_LINE;
          end
        end
        default: state_next = WAIT_FRAME;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q     <= 1'b0;
      mem_ce      <= 1'b0;
      mem_ad      <= 10'd0;
      mem_din     <= 32'd0;
      line_done   <= 1'b0;
      line_words  <= 10'd0;
      line_count  <= 9'd0;
      frame_start <= 1'b0;
      overflow    <= 1'b0;
      word_idx    <= 10'd0;
    end else begin
      mem_ce      <= 1'b0;
      line_done   <= 1'b0;
      frame_start <= 1'b0;
      if (cam_valid) vsync_q <= cam_vsync;
      if (vs_rise) begin
        frame_start <= 1'b1;
        line_count  <= 9'd0;
        overflow    <= 1'b0;
        word_idx    <= 10'd0;
      end else begin
        if (word_ready || flush_wr) begin
          if (word_idx < 10'(MAX_WORDS)) begin
            mem_ce   <= 1'b1;
            mem_ad   <= {bank, word_idx[BANK_BIT-1:0]};
            mem_din  <= word_ready ? word : half_word;
            word_idx <= word_idx + 10'd1;
          end else begin
            overflow <= 1'b1;
          end
        end
        if (finish) begin
          line_done  <= 1'b1;
          line_words <= word_idx;
          word_idx   <= 10'd0;
          if (line_count != LINE_COUNT_MAX) line_count <= line_count + 9'd1;
        end
      end
    end
  end

`ifdef LINE_PINGPONG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        bank <= 1'b0;
    else if (vs_rise) bank <= 1'b0;
    else if (finish)  bank <= ~bank;
  end
`else
  assign bank = 1'b0;
`endif

  assign mem_wre = mem_ce;

endmodule

// File: tb/tb_cam_line_packer.sv
// Self-checking bench for cam_line_packer: table vectors, random lines against a pixel/word model, corner sequences.
module tb_cam_line_packer;

  localparam int MAXW = 320;

  logic        clk = 1'b0;
  logic        reset;
  logic        cam_vsync, cam_href, cam_valid;
  logic [7:0]  cam_data;
  logic        mem_ce, mem_wre, line_done, frame_start, overflow;
  logic [9:0]  mem_ad, line_words;
  logic [31:0] mem_din;
  logic [8:0]  line_count;

  always #5 clk = ~clk;

  cam_line_packer dut (
    .clk         (clk),
    .reset       (reset),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_valid   (cam_valid),
    .cam_data    (cam_data),
    .mem_ce      (mem_ce),
    .mem_wre     (mem_wre),
    .mem_ad      (mem_ad),
    .mem_din     (mem_din),
    .line_done   (line_done),
    .line_words  (line_words),
    .line_count  (line_count),
    .frame_start (frame_start),
    .overflow    (overflow)
  );

  typedef struct {
    int          nbytes;
    int          exp_words;
    logic [31:0] exp_last_din;
  } vec_t;

  vec_t        vecs[8];
  int          checks = 0;
  int          passed = 0;
  logic [41:0] wr_log[$];
  int          done_log[$];
  int          fs_cnt = 0;
  int          wre_err = 0;
  int          exp_lc = 0;
  bit          exp_bank = 1'b0;
  bit          exp_ovf = 1'b0;
  int          obs_words;
  logic [31:0] obs_last;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_ce) wr_log.push_back({mem_ad, mem_din});
      if (line_done) done_log.push_back(int'(line_words));
      if (frame_start) fs_cnt++;
      if (mem_wre !== mem_ce) wre_err++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input logic vs, input logic hr, input logic [7:0] d, input int gap);
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
    cam_valid = 1'b1;
    @(posedge clk);
    #1;
    cam_valid = 1'b0;
    cam_vsync = 1'($urandom);
    cam_href  = 1'($urandom);
    cam_data  = 8'($urandom);
    idle(gap);
  endtask

  task automatic line_closed();
    if (exp_lc < 511) exp_lc++;
`ifdef LINE_PINGPONG_EN
    exp_bank = ~exp_bank;
`endif
  endtask

  // Model: bytes pair into pixels, pixels pair into words; a lone trailing pixel gets a zero upper half.
  task automatic run_line(input logic [7:0] q[$], input int gapmax);
    int          npix, nwords, nwr;
    logic [41:0] exp;
    wr_log.delete();
    done_log.delete();
    foreach (q[i]) sample(1'b0, 1'b1, q[i], $urandom_range(0, gapmax));
    sample(1'b0, 1'b0, 8'h00, 6);
    npix   = q.size() / 2;
    nwords = (npix + 1) / 2;
    nwr    = (nwords > MAXW) ? MAXW : nwords;
    if (nwords > MAXW) exp_ovf = 1'b1;
    check("write_count", 64'(wr_log.size()), 64'(nwr));
    for (int k = 0; k < nwr && k < wr_log.size(); k++) begin
      exp[41:32] = {exp_bank, 9'(k)};
      exp[15:0]  = {q[4*k], q[4*k+1]};
      if (2*k + 1 < npix) exp[31:16] = {q[4*k+2], q[4*k+3]};
      else                exp[31:16] = 16'h0000;
      check("write_ad_din", 64'(wr_log[k]), 64'(exp));
    end
    check("line_done_count", 64'(done_log.size()), 64'd1);
    obs_words = (done_log.size() > 0) ? done_log[0] : -1;
    check("line_words", 64'(obs_words), 64'(nwr));
    line_closed();
    check("line_count", 64'(line_count), 64'(exp_lc));
    check("overflow", 64'(overflow), 64'(exp_ovf));
    obs_last = (wr_log.size() > 0) ? wr_log[wr_log.size()-1][31:0] : 32'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    int         fs0;

    vecs[0] = '{8, 2, 32'h07080506};
    vecs[1] = '{6, 2, 32'h00000506};
    vecs[2] = '{7, 2, 32'h00000506};
    vecs[3] = '{4, 1, 32'h03040102};
    vecs[4] = '{5, 1, 32'h03040102};
    vecs[5] = '{2, 1, 32'h00000102};
    vecs[6] = '{3, 1, 32'h00000102};
    vecs[7] = '{1, 0, 32'h00000000};

    reset = 1'b1;
    cam_valid = 1'b0;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({mem_ce, mem_wre, mem_ad, mem_din, line_done, line_words,
                               line_count, frame_start, overflow}), 64'd0);
    reset = 1'b0;
    idle(2);

    sample(1'b1, 1'b0, 8'h00, 2);
    check("frame_start_first", 64'(fs_cnt), 64'd1);
    sample(1'b0, 1'b0, 8'h00, 2);

    // Write appears exactly one cycle after the fourth byte's valid cycle.
    wr_log.delete();
    done_log.delete();
    sample(1'b0, 1'b1, 8'h11, 0);
    sample(1'b0, 1'b1, 8'h22, 0);
    sample(1'b0, 1'b1, 8'h33, 0);
    sample(1'b0, 1'b1, 8'h44, 0);
    check("write_latency_ce", 64'({mem_ce, mem_wre}), 64'b11);
    check("write_latency_din", 64'(mem_din), 64'h33441122);
    check("write_latency_ad", 64'(mem_ad), 64'h000);
    sample(1'b0, 1'b0, 8'h00, 6);
    check("single_write_pulse", 64'(wr_log.size()), 64'd1);
    check("timing_line_done", 64'(done_log.size()), 64'd1);
    line_closed();

    for (int v = 0; v < 8; v++) begin
      q.delete();
      for (int b = 1; b <= vecs[v].nbytes; b++) q.push_back(8'(b));
      run_line(q, 1);
      check("vec_line_words", 64'(obs_words), 64'(vecs[v].exp_words));
      if (vecs[v].exp_words > 0) check("vec_last_din", 64'(obs_last), 64'(vecs[v].exp_last_din));
    end

    for (int r = 0; r < 20; r++) begin
      q.delete();
      for (int b = 0; b < $urandom_range(1, 48); b++) q.push_back(8'($urandom));
      run_line(q, 2);
    end

    q.delete();
    for (int b = 0; b < 1284; b++) q.push_back(8'($urandom));
    run_line(q, 0);
    check("overflow_set", 64'(overflow), 64'd1);
    fs0 = fs_cnt;
    sample(1'b1, 1'b0, 8'h00, 2);
    exp_ovf = 1'b0;
    exp_lc = 0;
    exp_bank = 1'b0;
    check("overflow_frame_start", 64'(fs_cnt), 64'(fs0 + 1));
    check("overflow_cleared", 64'(overflow), 64'd0);
    check("line_count_cleared", 64'(line_count), 64'd0);
    sample(1'b0, 1'b0, 8'h00, 1);

    // Frame sync mid-line: nothing further written, no line_done.
    wr_log.delete();
    done_log.delete();
    fs0 = fs_cnt;
    for (int b = 0; b < 10; b++) sample(1'b0, 1'b1, 8'(b + 8'h40), 1);
    idle(2);
    check("abort_prewrites", 64'(wr_log.size()), 64'd2);
    sample(1'b1, 1'b1, 8'hAA, 6);
    check("abort_no_writes", 64'(wr_log.size()), 64'd2);
    check("abort_no_line_done", 64'(done_log.size()), 64'd0);
    check("abort_frame_start", 64'(fs_cnt), 64'(fs0 + 1));
    check("abort_line_count", 64'(line_count), 64'd0);
    exp_lc = 0;
    exp_bank = 1'b0;
    sample(1'b0, 1'b0, 8'h00, 1);
    q.delete();
    for (int b = 1; b <= 8; b++) q.push_back(8'(b));
    run_line(q, 1);

    // Reset three bytes into a line.
    wr_log.delete();
    done_log.delete();
    for (int b = 0; b < 3; b++) sample(1'b0, 1'b1, 8'(b + 8'h70), 1);
    reset = 1'b1;
    idle(2);
    check("midline_reset_outputs", 64'({mem_ce, mem_wre, mem_ad, mem_din, line_done, line_words,
                                       line_count, frame_start, overflow}), 64'd0);
    check("midline_reset_no_write", 64'(wr_log.size() + done_log.size()), 64'd0);
    reset = 1'b0;
    exp_lc = 0;
    exp_bank = 1'b0;
    exp_ovf = 1'b0;
    idle(1);
    sample(1'b0, 1'b0, 8'h00, 1);
    q.delete();
    for (int b = 1; b <= 4; b++) q.push_back(8'(b + 8'h20));
    run_line(q, 1);

    check("wre_equals_ce", 64'(wre_err), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
